// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-side signals shared by the two core ports and the unified RAM.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              M_CSN;
    logic              M_WEN;
    logic [3:0]        M_BE;
    logic [ADDR_W-1:0] M_ADDR;
    logic [DATA_W-1:0] M_DOUT;
    logic [DATA_W-1:0] M_DI;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, M_DI,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output M_CSN, M_WEN, M_BE, M_ADDR, M_DOUT, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, M_DI,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  M_CSN, M_WEN, M_BE, M_ADDR, M_DOUT, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port RAM between the fetch and data ports (IDLE/WAIT/RESP).
// Define ARB_RR_EN for round-robin arbitration; default is data-over-instruction priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input logic              CLK,
    input logic              RSTn,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              owner_d;
    logic              lat_we;
    logic              i_rvalid_r;
    logic              d_rvalid_r;
    logic              busy_r;
    logic              csn_r;
    logic              wen_r;
    logic [3:0]        be_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] dout_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;

    logic d_win;
    logic i_gnt_c;
    logic d_gnt_c;

`ifdef ARB_RR_EN
    // High when the instruction port won the most recent grant.
    logic last_i;
    assign d_win = bus.d_req && (!bus.i_req || last_i);
`else
    assign d_win = bus.d_req;
`endif

    assign d_gnt_c = RSTn && (state == IDLE) && d_win;
    assign i_gnt_c = RSTn && (state == IDLE) && bus.i_req && !d_win;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state      <= IDLE;
            cnt        <= '0;
            owner_d    <= 1'b0;
            lat_we     <= 1'b0;
            i_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            busy_r     <= 1'b0;
            csn_r      <= 1'b1;
            wen_r      <= 1'b1;
            be_r       <= '0;
            addr_r     <= '0;
            dout_r     <= '0;
            i_rdata_r  <= '0;
            d_rdata_r  <= '0;
`ifdef ARB_RR_EN
            last_i     <= 1'b1;
`endif
        end else begin
            i_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_gnt_c || i_gnt_c) begin
                        state   <= WAIT;
                        cnt     <= LAT_M1;
                        owner_d <= d_gnt_c;
                        lat_we  <= d_gnt_c && bus.d_we;
                        busy_r  <= 1'b1;
                        csn_r   <= 1'b0;
                        wen_r   <= ~(d_gnt_c && bus.d_we);
                        // Fetches always read the whole word.
                        be_r    <= d_gnt_c ? bus.d_be    : 4'hF;
                        addr_r  <= d_gnt_c ? bus.d_addr  : bus.i_addr;
                        dout_r  <= d_gnt_c ? bus.d_wdata : '0;
`ifdef ARB_RR_EN
                        last_i  <= i_gnt_c;
`endif
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        csn_r <= 1'b1;
                        wen_r <= 1'b1;
                        if (!lat_we) begin
                            if (owner_d) d_rdata_r <= bus.M_DI;
                            else         i_rdata_r <= bus.M_DI;
                        end
                        if (owner_d) d_rvalid_r <= 1'b1;
                        else         i_rvalid_r <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.i_gnt    = i_gnt_c;
    assign bus.d_gnt    = d_gnt_c;
    assign bus.i_rvalid = i_rvalid_r;
    assign bus.d_rvalid = d_rvalid_r;
    assign bus.i_rdata  = i_rdata_r;
    assign bus.d_rdata  = d_rdata_r;
    assign bus.M_CSN    = csn_r;
    assign bus.M_WEN    = wen_r;
    assign bus.M_BE     = be_r;
    assign bus.M_ADDR   = addr_r;
    assign bus.M_DOUT   = dout_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic vs. a transaction model.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int L      = 2;

    logic CLK = 1'b0;
    logic RSTn;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(L)) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Transaction model: a grant at cycle g occupies the RAM for cycles g+1..g+L,
    // responds at g+L+1 and frees the arbiter for a new grant from g+L+2.
    bit                mdl_on = 1'b0;
    longint            cyc    = 0;
    bit                act;
    longint            tg;
    bit                t_d, t_we;
    logic [3:0]        t_be;
    logic [ADDR_W-1:0] t_addr;
    logic [DATA_W-1:0] t_wdata;
    logic [DATA_W-1:0] e_ir, e_dr;
    bit                last_i;

    always @(negedge CLK) begin
        bit inw, inr, e_ig, e_dg;
        inw  = 1'b0;
        inr  = 1'b0;
        e_ig = 1'b0;
        e_dg = 1'b0;
        cyc++;
        if (mdl_on) begin
            inw = act && (cyc >= tg + 1) && (cyc <= tg + L);
            inr = act && (cyc == tg + L + 1);
            if (RSTn && (!act || cyc >= tg + L + 2)) begin
                if (bus.d_req && bus.i_req) begin
`ifdef ARB_RR_EN
                    e_dg = last_i;
`else
                    e_dg = 1'b1;
`endif
                    e_ig = !e_dg;
                end else begin
                    e_dg = bus.d_req;
                    e_ig = bus.i_req;
                end
            end
            chk("m_i_gnt", bus.i_gnt, e_ig);
            chk("m_d_gnt", bus.d_gnt, e_dg);
            chk("m_csn", bus.M_CSN, !inw);
            chk("m_busy", bus.busy, inw || inr);
            chk("m_i_rvalid", bus.i_rvalid, inr && !t_d);
            chk("m_d_rvalid", bus.d_rvalid, inr && t_d);
            chk("m_i_rdata", bus.i_rdata, e_ir);
            chk("m_d_rdata", bus.d_rdata, e_dr);
            if (inw) begin
                chk("m_wen", bus.M_WEN, !t_we);
                chk("m_addr", bus.M_ADDR, t_addr);
                if (t_d) begin
                    chk("m_be", bus.M_BE, t_be);
                    chk("m_dout", bus.M_DOUT, t_wdata);
                end
                if (cyc == tg + L && !t_we) begin
                    if (t_d) e_dr = bus.M_DI;
                    else     e_ir = bus.M_DI;
                end
            end else begin
                chk("m_wen_idle", bus.M_WEN, 1'b1);
            end
        end
        if (!RSTn) begin
            mdl_on = 1'b1;
            act    = 1'b0;
            e_ir   = '0;
            e_dr   = '0;
            last_i = 1'b1;
        end else if (mdl_on && (e_ig || e_dg)) begin
            act     = 1'b1;
            tg      = cyc;
            t_d     = e_dg;
            t_we    = e_dg && bus.d_we;
            t_be    = bus.d_be;
            t_addr  = e_dg ? bus.d_addr : bus.i_addr;
            t_wdata = bus.d_wdata;
            last_i  = e_ig;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ig, dg, got;
        int w;
        logic exp_d;
        RSTn        = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_be    = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.M_DI    = '0;
        tick();
        @(negedge CLK);
        chk("rst_csn", bus.M_CSN, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
        tick();
        RSTn = 1'b1;

        // Fetch of 0x040
        bus.i_req  = 1'b1;
        bus.i_addr = 12'h040;
        bus.M_DI   = 32'h00A00093;
        @(negedge CLK); chk("fetch_gnt", bus.i_gnt, 1'b1);
        tick(); bus.i_req = 1'b0;
        @(negedge CLK); chk("fetch_csn_c1", bus.M_CSN, 1'b0);
        tick();
        @(negedge CLK); chk("fetch_csn_c2", bus.M_CSN, 1'b0);
        tick();
        @(negedge CLK);
        chk("fetch_rvalid", bus.i_rvalid, 1'b1);
        chk("fetch_rdata", bus.i_rdata, 32'h00A00093);
        chk("fetch_no_drvalid", bus.d_rvalid, 1'b0);

        // Partial store
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
        bus.d_addr = 12'h100; bus.d_wdata = 32'hDEADBEEF;
        @(negedge CLK); chk("st_gnt", bus.d_gnt, 1'b1);
        tick(); bus.d_req = 1'b0;
        @(negedge CLK);
        chk("st_wen", bus.M_WEN, 1'b0);
        chk("st_be", bus.M_BE, 4'b0011);
        chk("st_addr", bus.M_ADDR, 12'h100);
        chk("st_dout", bus.M_DOUT, 32'hDEADBEEF);
        tick();
        @(negedge CLK); chk("st_wen_c2", bus.M_WEN, 1'b0);
        tick();
        @(negedge CLK);
        chk("st_rvalid", bus.d_rvalid, 1'b1);
        chk("st_rdata_kept", bus.d_rdata, 32'h0);
        chk("st_irdata_kept", bus.i_rdata, 32'h00A00093);

        // Contention from reset: data first, fetch at cycle 4
        tick(); RSTn = 1'b0;
        tick(); RSTn = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 12'h080;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h200;
        @(negedge CLK);
        chk("cont_d_gnt", bus.d_gnt, 1'b1);
        chk("cont_i_wait", bus.i_gnt, 1'b0);
        tick(); bus.d_req = 1'b0;
        repeat (3) tick();
        @(negedge CLK); chk("cont_i_gnt_c4", bus.i_gnt, 1'b1);
        tick(); bus.i_req = 1'b0;
        repeat (2) tick();
        @(negedge CLK); chk("cont_i_rvalid_c7", bus.i_rvalid, 1'b1);

        // Both requests held: grant order and spacing
        tick(); RSTn = 1'b0;
        tick(); RSTn = 1'b1;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            got = 1'b0;
            w   = 0;
            while (!got && w < 12) begin
                @(negedge CLK);
                if (bus.i_gnt || bus.d_gnt) got = 1'b1;
                else w++;
            end
            if (!got) begin
                chk("order_timeout", 1'b0, 1'b1);
            end else begin
`ifdef ARB_RR_EN
                exp_d = (k % 2 == 0);
`else
                exp_d = 1'b1;
`endif
                chk("order", bus.d_gnt, exp_d);
                chk("order_gap", w, (k == 0) ? 0 : L + 1);
            end
        end
        tick(); bus.i_req = 1'b0; bus.d_req = 1'b0;
        repeat (L + 3) tick();

        // Reset in the last WAIT cycle of a load
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h300;
        @(negedge CLK); chk("rst_ld_gnt", bus.d_gnt, 1'b1);
        tick(); bus.d_req = 1'b0;
        tick(); RSTn = 1'b0;
        @(negedge CLK); chk("rst_ld_busy_before", bus.busy, 1'b1);
        tick(); RSTn = 1'b1; bus.d_req = 1'b1; bus.d_addr = 12'h304;
        @(negedge CLK);
        chk("rst_ld_csn", bus.M_CSN, 1'b1);
        chk("rst_ld_busy", bus.busy, 1'b0);
        chk("rst_ld_no_rvalid", bus.d_rvalid, 1'b0);
        chk("rst_ld_fresh_gnt", bus.d_gnt, 1'b1);
        tick(); bus.d_req = 1'b0;
        repeat (L + 2) tick();

        // Randomized traffic; requesters hold fields until granted
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            ig = bus.i_gnt;
            dg = bus.d_gnt;
            tick();
            bus.M_DI = DATA_W'($urandom);
            if (!bus.i_req || ig) begin
                bus.i_req  = ($urandom_range(0, 2) != 0);
                bus.i_addr = ADDR_W'($urandom);
            end
            if (!bus.d_req || dg) begin
                bus.d_req   = ($urandom_range(0, 2) != 0);
                bus.d_we    = $urandom_range(0, 1) != 0;
                bus.d_be    = 4'($urandom);
                bus.d_addr  = ADDR_W'($urandom);
                bus.d_wdata = DATA_W'($urandom);
            end
            RSTn = ($urandom_range(0, 199) != 0);
        end
        RSTn = 1'b1;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (L + 4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
